// File: rtl/vga_scanner.sv
// VGA raster scanner: pixel/line counters, renderer x/y, sync and blank generation.
// One pix_en tick from x/y to DAC outputs; pix_en low stalls counters and outputs.
module vga_scanner #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic [9:0] x,
  output logic [8:0] y,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       h_wrap;
  logic       v_wrap;
  logic       active;
  logic       hsync_raw;
  logic       vsync_raw;

  always_comb begin
    h_wrap      = (hcount == H_LAST);
    v_wrap      = (vcount == V_LAST);
    active      = (hcount < H_ACT) && (vcount < V_ACT);
    hsync_raw   = !((hcount >= H_SS) && (hcount < H_SE));
    vsync_raw   = !((vcount >= V_SS) && (vcount < V_SE));
    x           = active ? hcount : '0;
    y           = active ? vcount[8:0] : '0;
    frame_start = pix_en && (hcount == '0) && (vcount == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_en) begin
      hcount <= h_wrap ? '0 : hcount + 10'd1;
      if (h_wrap) begin
        vcount <= v_wrap ? '0 : vcount + 10'd1;
      end
    end
  end

  // Colour, sync and blank share one register stage so they stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else if (pix_en) begin
      vga_r       <= active ? r : '0;
      vga_g       <= active ? g : '0;
      vga_b       <= active ? b : '0;
      vga_hs      <= hsync_raw;
      vga_vs      <= vsync_raw;
      vga_blank_n <= active;
    end
  end

endmodule

// File: tb/tb_vga_scanner.sv
// Bench for vga_scanner: full horizontal timing, shortened vertical timing so a frame fits the run.
module tb_vga_scanner;

  localparam int HT    = 800;
  localparam int V_ACT = 20;
  localparam int VT    = V_ACT + 2 + 2 + 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       bl;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_en;
  logic [9:0] x;
  logic [8:0] y;
  logic [7:0] r, g, b;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, frame_start;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   p       = 0;
  exp_t last;
  exp_t sb[$];

  assign r = x[7:0];
  assign g = y[7:0];
  assign b = 8'hAA;

  always #5 clk = ~clk;

  vga_scanner #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(V_ACT), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .x(x), .y(y), .r(r), .g(g), .b(b),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (pixel index %0d)", tag, got, exp, p);
    end
  endtask

  task automatic chk_outs(input exp_t e);
    chk("vga_r", 32'(vga_r), 32'(e.r));
    chk("vga_g", 32'(vga_g), 32'(e.g));
    chk("vga_b", 32'(vga_b), 32'(e.b));
    chk("vga_hs", 32'(vga_hs), 32'(e.hs));
    chk("vga_vs", 32'(vga_vs), 32'(e.vs));
    chk("vga_blank_n", 32'(vga_blank_n), 32'(e.bl));
  endtask

  // Model is indexed by linear pixel number; h/v are derived, not counted.
  task automatic step(input logic en);
    exp_t e;
    int   mh, mv;
    logic act;
    pix_en = en;
    mh  = p % HT;
    mv  = p / HT;
    act = (mh < 640) && (mv < V_ACT);
    #1;
    chk("x", 32'(x), act ? 32'(mh) : 32'd0);
    chk("y", 32'(y), act ? 32'(mv) : 32'd0);
    chk("frame_start", 32'(frame_start), 32'(en && (p == 0)));
    if (en) begin
      e.r  = act ? 8'(mh) : 8'd0;
      e.g  = act ? 8'(mv) : 8'd0;
      e.b  = act ? 8'hAA : 8'd0;
      e.hs = !((mh >= 656) && (mh < 752));
      e.vs = !((mv >= V_ACT + 2) && (mv < V_ACT + 4));
      e.bl = act;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (en) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        last = sb.pop_front();
      end
      p = (p + 1) % (HT * VT);
    end
    chk_outs(last);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      pix_en = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("rst_vga_r", 32'(vga_r), 32'd0);
      chk("rst_vga_g", 32'(vga_g), 32'd0);
      chk("rst_vga_b", 32'(vga_b), 32'd0);
      chk("rst_hs", 32'(vga_hs), 32'd1);
      chk("rst_vs", 32'(vga_vs), 32'd1);
      chk("rst_blank_n", 32'(vga_blank_n), 32'd0);
      chk("rst_x", 32'(x), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
    end
    reset = 1'b0;
    p = 0;
    sb.delete();
    last.r = 8'd0; last.g = 8'd0; last.b = 8'd0;
    last.hs = 1'b1; last.vs = 1'b1; last.bl = 1'b0;
  endtask

  initial begin
    int   hs_low, first_hs, vs_low, fs_cnt, fs_at, pp;
    int   fall0, fall1;
    logic prev_hs;
    reset  = 1'b1;
    pix_en = 1'b1;
    do_reset(3);

    // One full frame with pix_en held high.
    hs_low = 0; first_hs = -1; vs_low = 0; fs_cnt = 0; fs_at = -1;
    pix_en = 1'b1;
    #1;
    chk("fs_cycle0", 32'(frame_start), 32'd1);
    for (int i = 0; i < HT * VT; i++) begin
      pp = p;
      step(1'b1);
      if (pp == 3 * HT + 5) begin
        chk("px5_3_r", 32'(vga_r), 32'd5);
        chk("px5_3_g", 32'(vga_g), 32'd3);
        chk("px5_3_b", 32'(vga_b), 32'hAA);
        chk("px5_3_blank_n", 32'(vga_blank_n), 32'd1);
      end
      if (pp == 640) begin
        chk("h640_r", 32'(vga_r), 32'd0);
        chk("h640_b", 32'(vga_b), 32'd0);
        chk("h640_blank_n", 32'(vga_blank_n), 32'd0);
      end
      if (pp < HT && !vga_hs) begin
        hs_low++;
        if (first_hs < 0) first_hs = pp + 1;
      end
      if (!vga_vs) vs_low++;
      if (frame_start) begin
        fs_cnt++;
        fs_at = i + 1;
      end
    end
    chk("hs_low_per_line", 32'(hs_low), 32'd96);
    chk("hs_first_low_tick", 32'(first_hs), 32'd657);
    chk("vs_low_cycles", 32'(vs_low), 32'(2 * HT));
    chk("fs_count", 32'(fs_cnt), 32'd1);
    chk("fs_period", 32'(fs_at), 32'(HT * VT));
    chk("wrap_x", 32'(x), 32'd0);
    chk("wrap_y", 32'(y), 32'd0);
    chk("wrap_fs", 32'(frame_start), 32'd1);

    // Half-rate pixel clock: line period doubles.
    fall0 = -1; fall1 = -1;
    prev_hs = vga_hs;
    for (int i = 0; i < 3 * 2 * HT; i++) begin
      step(1'((i % 2) == 0));
      if (prev_hs && !vga_hs) begin
        if (fall0 < 0) fall0 = i;
        else if (fall1 < 0) fall1 = i;
      end
      prev_hs = vga_hs;
    end
    chk("half_rate_line_period", 32'(fall1 - fall0), 32'd1600);

    // Abandon a frame mid-way with reset.
    for (int i = 0; i < HT * VT && p != 10 * HT + 300; i++) begin
      step(1'b1);
    end
    chk("pre_reset_pos", 32'(p), 32'(10 * HT + 300));
    do_reset(3);
    pix_en = 1'b1;
    #1;
    chk("post_rst_fs", 32'(frame_start), 32'd1);
    step(1'b1);

    // Random pix_en qualifier.
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
